// File: rtl/capture_pkg.sv
// Shared types and defaults for the pre/post-trigger capture ring controller.
package capture_pkg;

  localparam int unsigned ADDR_WIDTH_DEF = 13;
  localparam int unsigned DATA_WIDTH_DEF = 10;
  localparam int unsigned RD_LATENCY_DEF = 1;

  // Encoding is visible on the state output, so the values are fixed.
  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StPre   = 3'd1,
    StArmed = 3'd2,
    StPost  = 3'd3,
    StDone  = 3'd4,
    StRead  = 3'd5
  } state_e;

  function automatic int unsigned depth(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

endpackage

// File: rtl/capture_ring_ctrl_if.sv
// Dual-port sample RAM bus: port A write side, port B read side.
interface capture_ring_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = capture_pkg::ADDR_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH = capture_pkg::DATA_WIDTH_DEF
);

  logic [ADDR_WIDTH-1:0] ram_wr_addr;
  logic [DATA_WIDTH-1:0] ram_wr_data;
  logic                  ram_wr_en;
  logic [ADDR_WIDTH-1:0] ram_rd_addr;
  logic [DATA_WIDTH-1:0] ram_rd_data;

  modport master (
    output ram_wr_addr,
    output ram_wr_data,
    output ram_wr_en,
    output ram_rd_addr,
    input  ram_rd_data
  );

  modport slave (
    input  ram_wr_addr,
    input  ram_wr_data,
    input  ram_wr_en,
    input  ram_rd_addr,
    output ram_rd_data
  );

endinterface

// File: rtl/rd_latency_pipe.sv
// Delays the issued-read valid/last flags to line up with RAM read data.
module rd_latency_pipe #(
  parameter int unsigned LATENCY = 1
) (
  input  logic clk_i,
  input  logic clr_i,
  input  logic valid_i,
  input  logic last_i,
  output logic valid_o,
  output logic last_o
);

  logic [LATENCY-1:0] valid_q, valid_d;
  logic [LATENCY-1:0] last_q, last_d;

  always_comb begin
    valid_d    = valid_q << 1;
    valid_d[0] = valid_i;
    last_d     = last_q << 1;
    last_d[0]  = last_i;
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      valid_q <= '0;
      last_q  <= '0;
    end else begin
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign valid_o = valid_q[LATENCY-1];
  assign last_o  = last_q[LATENCY-1];

endmodule

// File: rtl/capture_ring_ctrl.sv
// Sequences a dual-port sample RAM as a pre/post-trigger ring buffer and replays
// the frozen capture oldest-first.
module capture_ring_ctrl
  import capture_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned RD_LATENCY = RD_LATENCY_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  arm,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] pretrig_len,
  input  logic [DATA_WIDTH-1:0] samp_data,
  input  logic                  samp_valid,
  input  logic                  trig,
  capture_ring_ctrl_if.master   ram,
  input  logic                  rd_start,
  input  logic                  rd_req,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  rd_last,
  output logic [ADDR_WIDTH-1:0] trig_addr,
  output logic                  done,
  output logic [2:0]            state
);

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [ADDR_WIDTH:0]   cnt_t;

  localparam cnt_t CntFull = cnt_t'(depth(ADDR_WIDTH));

  state_e state_q, state_d;
  addr_t  wr_ptr_q, wr_ptr_d;
  addr_t  rd_ptr_q, rd_ptr_d;
  addr_t  trig_addr_q, trig_addr_d;
  addr_t  plen_q, plen_d;
  addr_t  samp_cnt_q, samp_cnt_d;
  addr_t  post_cnt_q, post_cnt_d;
  cnt_t   rd_cnt_q, rd_cnt_d;
  logic   done_q, done_d;

  logic capturing;
  logic wr_fire;
  logic arm_ok;
  logic rd_issue;
  logic rd_issue_last;
  logic pipe_valid;
  logic pipe_last;
  logic clr;

  assign clr           = rst | abort;
  assign capturing     = state_q inside {StPre, StArmed, StPost};
  assign wr_fire       = capturing && samp_valid;
  assign arm_ok        = arm && (state_q inside {StIdle, StDone});
  assign rd_issue      = (state_q == StRead) && rd_req && (rd_cnt_q != CntFull);
  assign rd_issue_last = rd_issue && (rd_cnt_q == CntFull - cnt_t'(1));

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    trig_addr_d = trig_addr_q;
    plen_d      = plen_q;
    samp_cnt_d  = samp_cnt_q;
    post_cnt_d  = post_cnt_q;
    rd_cnt_d    = rd_cnt_q;

    if (arm_ok) begin
      // pretrig_len is ADDR_WIDTH bits wide, so it never exceeds DEPTH-1.
      plen_d     = pretrig_len;
      wr_ptr_d   = '0;
      samp_cnt_d = '0;
      state_d    = (pretrig_len != '0) ? StPre : StArmed;
    end else begin
      if (wr_fire) begin
        wr_ptr_d = wr_ptr_q + addr_t'(1);
      end
      case (state_q)
        StPre: begin
          if (samp_valid) begin
            samp_cnt_d = samp_cnt_q + addr_t'(1);
            if (samp_cnt_q == plen_q - addr_t'(1)) begin
              state_d = StArmed;
            end
          end
        end
        StArmed: begin
          if (samp_valid && trig) begin
            trig_addr_d = wr_ptr_q;
            // DEPTH-1-plen samples remain after the trigger sample.
            post_cnt_d  = ~plen_q;
            state_d     = (post_cnt_d == '0) ? StDone : StPost;
          end
        end
        StPost: begin
          if (samp_valid) begin
            post_cnt_d = post_cnt_q - addr_t'(1);
            if (post_cnt_q == addr_t'(1)) begin
              state_d = StDone;
            end
          end
        end
        StDone: begin
          if (rd_start) begin
            rd_ptr_d = trig_addr_q - plen_q;
            rd_cnt_d = '0;
            state_d  = StRead;
          end
        end
        StRead: begin
          if (rd_issue) begin
            rd_ptr_d = rd_ptr_q + addr_t'(1);
            rd_cnt_d = rd_cnt_q + cnt_t'(1);
          end
          if (pipe_last) begin
            state_d = StDone;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      trig_addr_q <= '0;
      plen_q      <= '0;
      samp_cnt_q  <= '0;
      post_cnt_q  <= '0;
      rd_cnt_q    <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      trig_addr_q <= trig_addr_d;
      plen_q      <= plen_d;
      samp_cnt_q  <= samp_cnt_d;
      post_cnt_q  <= post_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      done_q      <= done_d;
    end
  end

  rd_latency_pipe #(
    .LATENCY (RD_LATENCY)
  ) u_rd_latency_pipe (
    .clk_i   (clk),
    .clr_i   (clr),
    .valid_i (rd_issue),
    .last_i  (rd_issue_last),
    .valid_o (pipe_valid),
    .last_o  (pipe_last)
  );

  assign ram.ram_wr_en   = wr_fire;
  assign ram.ram_wr_addr = wr_ptr_q;
  assign ram.ram_wr_data = samp_data;
  assign ram.ram_rd_addr = rd_ptr_q;

  assign rd_data   = ram.ram_rd_data;
  assign rd_valid  = pipe_valid;
  assign rd_last   = pipe_last;
  assign trig_addr = trig_addr_q;
  assign done      = done_q;
  assign state     = state_q;

endmodule

// File: tb/tb_capture_ring_ctrl.sv
// Directed bench for capture_ring_ctrl with a 512-deep, latency-1 behavioural RAM.
module tb_capture_ring_ctrl;

  localparam int unsigned AW    = 9;
  localparam int unsigned DW    = 10;
  localparam int          DEPTH = 512;

  logic          clk = 1'b0;
  logic          rst, arm, abort, samp_valid, trig, rd_start, rd_req;
  logic [AW-1:0] pretrig_len;
  logic [DW-1:0] samp_data, rd_data;
  logic          rd_valid, rd_last, done;
  logic [AW-1:0] trig_addr;
  logic [2:0]    state;

  int n_checks = 0;
  int n_fail   = 0;

  // Stream results shared with the test sequence.
  int n_samp, trig_iter, done_iter;

  capture_ring_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ram_if ();

  capture_ring_ctrl #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .RD_LATENCY (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .arm         (arm),
    .abort       (abort),
    .pretrig_len (pretrig_len),
    .samp_data   (samp_data),
    .samp_valid  (samp_valid),
    .trig        (trig),
    .ram         (ram_if),
    .rd_start    (rd_start),
    .rd_req      (rd_req),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .rd_last     (rd_last),
    .trig_addr   (trig_addr),
    .done        (done),
    .state       (state)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] mem_rd_q;

  always @(posedge clk) begin
    if (ram_if.ram_wr_en) mem[ram_if.ram_wr_addr] <= ram_if.ram_wr_data;
    mem_rd_q <= mem[ram_if.ram_rd_addr];
  end

  assign ram_if.ram_rd_data = mem_rd_q;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_arm(input int plen);
    @(negedge clk);
    pretrig_len = AW'(plen);
    arm         = 1'b1;
    @(negedge clk);
    arm = 1'b0;
  endtask

  // Streams counter samples 0,1,2.. until done (or until POST when stop_post).
  task automatic stream(input string tag, input int trig_idx, input bit gapped,
                        input bit stop_post);
    int idx;
    bit v;
    idx       = 0;
    trig_iter = -1;
    done_iter = -1;
    for (int it = 0; it < 4000; it++) begin
      @(negedge clk);
      if (!stop_post && done === 1'b1) begin
        done_iter = it;
        break;
      end
      if (stop_post && state === 3'd3) begin
        done_iter = it;
        break;
      end
      v          = gapped ? 1'($urandom_range(0, 1)) : 1'b1;
      samp_valid = v;
      samp_data  = idx[DW-1:0];
      // In gapped mode trig also rides every idle cycle and must be ignored.
      trig       = (v && idx == trig_idx) || (gapped && !v);
      if (v && idx == trig_idx) trig_iter = it;
      if (v && idx == 5) begin
        #1;
        check_eq({tag, "_wr_en"}, 32'(ram_if.ram_wr_en), 1);
        check_eq({tag, "_wr_addr"}, 32'(ram_if.ram_wr_addr), 5);
      end
      if (v) idx++;
    end
    samp_valid = 1'b0;
    trig       = 1'b0;
    n_samp     = idx;
    check_eq({tag, "_stream_ended"}, 32'(done_iter >= 0), 1);
  endtask

  task automatic replay(input string tag, input int first, input bit gapped, input int start_addr);
    int k, last_k, errs, lat_errs, issued;
    bit prev_issue, r;
    logic [DW-1:0] exp_w;
    k = 0; last_k = -1; errs = 0; lat_errs = 0; issued = 0; prev_issue = 1'b0;
    @(negedge clk);
    rd_start = 1'b1;
    @(negedge clk);
    rd_start = 1'b0;
    check_eq({tag, "_state_read"}, 32'(state), 5);
    check_eq({tag, "_start_addr"}, 32'(ram_if.ram_rd_addr), 32'(start_addr));
    for (int it = 0; it < 4000; it++) begin
      if (rd_valid !== prev_issue) lat_errs++;
      if (rd_valid === 1'b1) begin
        exp_w = DW'(first + k);
        if (rd_data !== exp_w) errs++;
        k++;
        if (rd_last === 1'b1) last_k = k;
      end else if (rd_last !== 1'b0) begin
        lat_errs++;
      end
      if (last_k > 0) break;
      r          = gapped ? 1'($urandom_range(0, 1)) : 1'b1;
      rd_req     = r;
      prev_issue = r && (issued < DEPTH);
      if (prev_issue) issued++;
      @(negedge clk);
    end
    rd_req = 1'b0;
    check_eq({tag, "_rd_last_word"}, 32'(last_k), 512);
    check_eq({tag, "_data_errs"}, 32'(errs), 0);
    check_eq({tag, "_valid_timing_errs"}, 32'(lat_errs), 0);
    @(negedge clk);
    check_eq({tag, "_back_to_done"}, 32'(state), 4);
    check_eq({tag, "_done_level"}, 32'(done), 1);
  endtask

  initial begin
    int seen;
    rst = 1'b1; arm = 1'b0; abort = 1'b0; samp_valid = 1'b0; trig = 1'b0;
    rd_start = 1'b0; rd_req = 1'b0; pretrig_len = '0; samp_data = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_state", 32'(state), 0);
    check_eq("rst_done", 32'(done), 0);
    check_eq("rst_wr_en", 32'(ram_if.ram_wr_en), 0);
    check_eq("rst_rd_valid", 32'(rd_valid), 0);
    check_eq("rst_rd_last", 32'(rd_last), 0);
    check_eq("rst_trig_addr", 32'(trig_addr), 0);
    check_eq("rst_wr_addr", 32'(ram_if.ram_wr_addr), 0);
    check_eq("rst_rd_addr", 32'(ram_if.ram_rd_addr), 0);
    rst = 1'b0;

    // Basic capture: 100 pre-trigger, trigger on sample 300, 411 post.
    do_arm(100);
    check_eq("t1_state_pre", 32'(state), 1);
    stream("t1", 300, 1'b0, 1'b0);
    check_eq("t1_samples", 32'(n_samp), 712);
    check_eq("t1_trig_addr", 32'(trig_addr), 300);
    check_eq("t1_post_len", 32'(done_iter - trig_iter), 412);
    replay("t1", 200, 1'b0, 200);

    // No pre-trigger: straight to ARMED, trigger on the first sample.
    do_arm(0);
    check_eq("t2_state_armed", 32'(state), 2);
    stream("t2", 0, 1'b0, 1'b0);
    check_eq("t2_samples", 32'(n_samp), 512);
    check_eq("t2_trig_addr", 32'(trig_addr), 0);
    replay("t2", 0, 1'b0, 0);

    // Maximum pre-trigger: trigger is the final sample, DONE right after.
    do_arm(511);
    check_eq("t3_state_pre", 32'(state), 1);
    stream("t3", 511, 1'b0, 1'b0);
    check_eq("t3_samples", 32'(n_samp), 512);
    check_eq("t3_trig_addr", 32'(trig_addr), 511);
    check_eq("t3_done_next_cycle", 32'(done_iter - trig_iter), 1);
    replay("t3", 0, 1'b0, 0);

    // Wrap: trigger after 1000 ARMED samples, replay crosses 511 -> 0.
    do_arm(20);
    stream("t4", 1020, 1'b0, 1'b0);
    check_eq("t4_samples", 32'(n_samp), 1512);
    check_eq("t4_trig_addr", 32'(trig_addr), 508);
    check_eq("t4_post_len", 32'(done_iter - trig_iter), 492);
    replay("t4", 1000, 1'b0, 488);

    // Gapped samples and read requests; idle-cycle triggers are ignored.
    do_arm(100);
    stream("t5", 300, 1'b1, 1'b0);
    check_eq("t5_samples", 32'(n_samp), 712);
    check_eq("t5_trig_addr", 32'(trig_addr), 300);
    replay("t5", 200, 1'b1, 200);

    // Abort in POST with a sample still on the bus.
    do_arm(10);
    stream("t6", 50, 1'b0, 1'b1);
    check_eq("t6_state_post", 32'(state), 3);
    abort = 1'b1; samp_valid = 1'b1; samp_data = 10'd999;
    @(negedge clk);
    abort = 1'b0;
    #1;
    check_eq("t6_state_idle", 32'(state), 0);
    check_eq("t6_wr_en", 32'(ram_if.ram_wr_en), 0);
    check_eq("t6_wr_addr", 32'(ram_if.ram_wr_addr), 0);
    check_eq("t6_trig_addr", 32'(trig_addr), 0);
    check_eq("t6_done", 32'(done), 0);
    samp_valid = 1'b0;

    // Reset during READ with a read in flight; arm is ignored in READ.
    do_arm(0);
    stream("t7", 0, 1'b0, 1'b0);
    @(negedge clk);
    rd_start = 1'b1;
    @(negedge clk);
    rd_start = 1'b0;
    rd_req   = 1'b1;
    @(negedge clk);
    check_eq("t7_rd_valid_inflight", 32'(rd_valid), 1);
    pretrig_len = 9'd7;
    arm         = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    check_eq("t7_arm_ignored", 32'(state), 5);
    rst = 1'b1;
    @(negedge clk);
    rst    = 1'b0;
    rd_req = 1'b0;
    check_eq("t7_rd_valid", 32'(rd_valid), 0);
    check_eq("t7_rd_last", 32'(rd_last), 0);
    check_eq("t7_state", 32'(state), 0);
    check_eq("t7_done", 32'(done), 0);
    check_eq("t7_trig_addr", 32'(trig_addr), 0);
    check_eq("t7_rd_addr", 32'(ram_if.ram_rd_addr), 0);
    check_eq("t7_wr_addr", 32'(ram_if.ram_wr_addr), 0);
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rd_valid !== 1'b0) seen++;
    end
    check_eq("t7_no_late_valid", 32'(seen), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
